rr_fifo_arbiter: RTL and testbench

//  Downstream consumer of four source FIFOs (6-bit words, synchronous read).

---
 rtl/rr_fifo_arbiter.sv | 68 ++++++
 tb/tb_rr_fifo_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: round-robin drain of four source FIFOs into one destination FIFO
module rr_fifo_arbiter #(
  parameter int DATA_W = 6,
  parameter int NSRC   = 4
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic [NSRC-1:0]          src_empty,
  input  logic [NSRC*DATA_W-1:0]   src_data,
  input  logic                     dst_al_full,
  input  logic                     dst_full,
  output logic [NSRC-1:0]          src_rd,
  output logic [DATA_W-1:0]        data_out,
  output logic                     dst_wr,
  output logic [$clog2(NSRC)-1:0]  grant_id,
  output logic                     err_arb,
  output logic                     idle
);
  localparam int IW = $clog2(NSRC);
  logic [IW-1:0]     ptr_q, ptr_d, gid_q, gid_d, sel_q, gnt_idx, idx;
  logic [NSRC-1:0]   rd_q, rd_d, elig;
  logic              found, vld_q, wr_q, err_q;
  logic [DATA_W-1:0] data_q;
  // src_rd doubles as the last-grant mask: a source just read has a stale empty flag
  always_comb begin
    elig    = ~src_empty & ~rd_q & {NSRC{~dst_al_full}};
    found   = 1'b0;
    gnt_idx = ptr_q;
    idx     = ptr_q;
    for (int j = NSRC - 1; j >= 0; j--) begin
      idx = ptr_q + IW'(j);
      if (elig[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    rd_d  = found ? NSRC'(1) << gnt_idx : '0;
    ptr_d = found ? gnt_idx + 1'b1 : ptr_q;
    gid_d = found ? gnt_idx : gid_q;
  end
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ptr_q  <= '0;
      rd_q   <= '0;
      gid_q  <= '0;
      vld_q  <= 1'b0;
      sel_q  <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rd_q  <= rd_d;
      gid_q <= gid_d;
      vld_q <= |rd_q;
      sel_q <= gid_q;
      wr_q  <= vld_q & ~dst_full;
      err_q <= err_q | (vld_q & dst_full);
      if (vld_q & ~dst_full) data_q <= src_data[DATA_W*int'(sel_q) +: DATA_W];
    end
  end
  assign src_rd   = rd_q;
  assign data_out = data_q;
  assign dst_wr   = wr_q;
  assign grant_id = gid_q;
  assign err_arb  = err_q;
  assign idle     = ~|rd_q & ~vld_q;
endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// tb_rr_fifo_arbiter: directed vector table plus hand sequences for single-source drain and reset abort
module tb_rr_fifo_arbiter;
  logic        clk = 1'b0;
  logic        rst_sig = 1'b0;
  logic [3:0]  src_empty = 4'hf;
  logic [23:0] src_data = '0;
  logic        dst_al_full = 1'b0;
  logic        dst_full = 1'b0;
  logic [3:0]  src_rd;
  logic [5:0]  data_out;
  logic        dst_wr;
  logic [1:0]  grant_id;
  logic        err_arb;
  logic        idle;
  int total = 0;
  int bad = 0;

  rr_fifo_arbiter dut (
    .clk(clk), .RESET(rst_sig), .src_empty(src_empty), .src_data(src_data),
    .dst_al_full(dst_al_full), .dst_full(dst_full), .src_rd(src_rd),
    .data_out(data_out), .dst_wr(dst_wr), .grant_id(grant_id),
    .err_arb(err_arb), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] empty;
    logic       alf;
    logic       full;
    logic [3:0] rd;
    logic       wr;
    logic [5:0] data;
    logic [1:0] gid;
    logic       idl;
    logic       err;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " src_rd"}, 32'(src_rd), 0);
    chk({tag, " dst_wr"}, 32'(dst_wr), 0);
    chk({tag, " data_out"}, 32'(data_out), 0);
    chk({tag, " grant_id"}, 32'(grant_id), 0);
    chk({tag, " err_arb"}, 32'(err_arb), 0);
    chk({tag, " idle"}, 32'(idle), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_sig = 1'b1;
    repeat (2) tick();
    rst_sig = 1'b0;
  endtask

  logic [5:0] q0 [3];
  logic [3:0] exp_rd0 [8];
  logic       exp_wr0 [8];
  logic [5:0] exp_d0  [8];

  initial begin
    vec[0]  = '{4'h0, 1'b0, 1'b0, 4'b0001, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0};
    vec[1]  = '{4'h0, 1'b0, 1'b0, 4'b0010, 1'b0, 6'h00, 2'd1, 1'b0, 1'b0};
    vec[2]  = '{4'h0, 1'b0, 1'b0, 4'b0100, 1'b1, 6'h05, 2'd2, 1'b0, 1'b0};
    vec[3]  = '{4'h0, 1'b0, 1'b0, 4'b1000, 1'b1, 6'h11, 2'd3, 1'b0, 1'b0};
    vec[4]  = '{4'h0, 1'b0, 1'b0, 4'b0001, 1'b1, 6'h22, 2'd0, 1'b0, 1'b0};
    vec[5]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 6'h33, 2'd0, 1'b0, 1'b0};
    vec[6]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 6'h05, 2'd0, 1'b1, 1'b0};
    vec[7]  = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 6'h05, 2'd0, 1'b1, 1'b0};
    vec[8]  = '{4'h0, 1'b0, 1'b0, 4'b0010, 1'b0, 6'h05, 2'd1, 1'b0, 1'b0};
    vec[9]  = '{4'h0, 1'b0, 1'b0, 4'b0100, 1'b0, 6'h05, 2'd2, 1'b0, 1'b0};
    vec[10] = '{4'h0, 1'b0, 1'b0, 4'b1000, 1'b1, 6'h11, 2'd3, 1'b0, 1'b0};
    vec[11] = '{4'h0, 1'b0, 1'b1, 4'b0001, 1'b0, 6'h11, 2'd0, 1'b0, 1'b1};
    vec[12] = '{4'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 6'h33, 2'd1, 1'b0, 1'b1};
    q0 = '{6'h0a, 6'h0b, 6'h0c};
    exp_rd0 = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    exp_wr0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_d0  = '{6'h00, 6'h00, 6'h0a, 6'h0a, 6'h0b, 6'h0b, 6'h0c, 6'h0c};

    // T1: reset with random inputs
    #2;
    src_empty = 4'($urandom);
    src_data = 24'($urandom);
    dst_al_full = 1'($urandom);
    dst_full = 1'($urandom);
    rst_sig = 1'b1;
    #1;
    chk_reset("t1 async");
    repeat (2) tick();
    chk_reset("t1 held");
    src_empty = 4'hf;
    dst_al_full = 1'b0;
    dst_full = 1'b0;
    rst_sig = 1'b0;

    // T2: lone source 0 with three words, empty flag updates on the edge that samples the read
    begin
      int cnt = 3;
      int head = 0;
      logic [3:0] rd_prev;
      src_data = '0;
      src_empty = 4'b1110;
      for (int c = 0; c < 8; c++) begin
        rd_prev = src_rd;
        tick();
        if (rd_prev[0]) begin
          src_data[5:0] = q0[head];
          head++;
          cnt--;
        end
        src_empty[0] = (cnt == 0);
        chk($sformatf("t2 c%0d src_rd", c), 32'(src_rd), 32'(exp_rd0[c]));
        chk($sformatf("t2 c%0d dst_wr", c), 32'(dst_wr), 32'(exp_wr0[c]));
        chk($sformatf("t2 c%0d data_out", c), 32'(data_out), 32'(exp_d0[c]));
      end
      chk("t2 idle", 32'(idle), 1);
    end

    // T3-T5: all sources busy, almost-full throttle, full overflow
    src_empty = 4'hf;
    do_reset();
    src_data = {6'h33, 6'h22, 6'h11, 6'h05};
    for (int i = 0; i < 13; i++) begin
      src_empty = vec[i].empty;
      dst_al_full = vec[i].alf;
      dst_full = vec[i].full;
      tick();
      chk($sformatf("v%0d src_rd", i), 32'(src_rd), 32'(vec[i].rd));
      chk($sformatf("v%0d dst_wr", i), 32'(dst_wr), 32'(vec[i].wr));
      chk($sformatf("v%0d data_out", i), 32'(data_out), 32'(vec[i].data));
      chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vec[i].gid));
      chk($sformatf("v%0d idle", i), 32'(idle), 32'(vec[i].idl));
      chk($sformatf("v%0d err_arb", i), 32'(err_arb), 32'(vec[i].err));
    end

    // T6: reset with two words in flight, pointer back to source 0
    rst_sig = 1'b1;
    #1;
    chk_reset("t6 async");
    tick();
    rst_sig = 1'b0;
    tick();
    chk("t6 first grant", 32'(src_rd), 32'b0001);
    chk("t6 no wr 1", 32'(dst_wr), 0);
    tick();
    chk("t6 second grant", 32'(src_rd), 32'b0010);
    chk("t6 no wr 2", 32'(dst_wr), 0);
    chk("t6 err cleared", 32'(err_arb), 0);
    tick();
    chk("t6 wr resumes", 32'(dst_wr), 1);
    chk("t6 wr data", 32'(data_out), 32'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
